// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Holds the FSM state enum, the display image bundle and a nibble picker.
package seg_pkg;

   localparam int N_DIGITS = 8;
   localparam int NIB_W = 4;
   localparam int IDX_W = 3;
   localparam logic [N_DIGITS-1:0] LED_EN_OFF = 8'hFF;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_ON    = 1'b1
   } state_t;

   typedef struct packed {
      logic [N_DIGITS*NIB_W-1:0] data;
      logic [N_DIGITS-1:0]       mask;
      logic [N_DIGITS-1:0]       blink;
      logic                      boom;
   } img_t;

   function automatic logic [NIB_W-1:0] nib(
      input logic [N_DIGITS*NIB_W-1:0] d,
      input logic [IDX_W-1:0]          i
   );
      return d[{i, 2'b00} +: NIB_W];
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bus between image writer, scan controller and segment decoder/pins.
// master: writer side (drives image + load); slave: scan controller.
interface seg_scan_ctrl_if;

   logic [31:0] disp_data;
   logic [7:0]  disp_mask;
   logic [7:0]  blink_mask;
   logic        boom_in;
   logic        load;
   logic        load_ack;
   logic [3:0]  num_set;
   logic        boom1;
   logic [7:0]  led_en;
   logic        frame_start;

   modport master (
      output disp_data, disp_mask, blink_mask, boom_in, load,
      input  load_ack, num_set, boom1, led_en, frame_start
   );

   modport slave (
      input  disp_data, disp_mask, blink_mask, boom_in, load,
      output load_ack, num_set, boom1, led_en, frame_start
   );

endinterface

// File: rtl/seg_blink_timer.sv
// Frame counter and blink phase toggle, advanced once per frame tick.
// Ports: clk, rst (async high), frame_tick in; blink_phase out.
module seg_blink_timer #(
   parameter int BLINK_FRAMES = 250
)(
   input  logic clk,
   input  logic rst,
   input  logic frame_tick,
   output logic blink_phase
);

   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] LAST = BW'(BLINK_FRAMES - 1);

   logic [BW-1:0] fcnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt        <= '0;
         blink_phase <= 1'b0;
      end else if (frame_tick) begin
         if (fcnt == LAST) begin
            fcnt        <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed 7-seg scan controller with double-buffered image.
// Ports: clk, rst (async high); bus (slave): image/load in, decoder/pins out.
module seg_scan_ctrl #(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_FRAMES = 250
)(
   input logic           clk,
   input logic           rst,
   seg_scan_ctrl_if.slave bus
);

   import seg_pkg::*;

   localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ?
                            DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] ON_LAST    = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   state_t           state, state_d;
   logic [IDX_W-1:0] idx, idx_d;
   logic [CW-1:0]    cnt, cnt_d;
   // Set by reset so the first clock acts as a frame boundary.
   logic             boot;
   logic             boundary, enter_blank;
   logic             blank_done, on_done;

   img_t             shadow, shadow_d, pend;
   logic             pend_valid, commit;
   logic             blink_phase, vis;

   logic [7:0]       led_en_q, led_en_d;
   logic [NIB_W-1:0] num_set_q, num_set_d;
   logic             boom1_q, boom1_d;
   logic             load_ack_q, frame_start_q;

   seg_blink_timer #(
      .BLINK_FRAMES(BLINK_FRAMES)
   ) u_blink (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (boundary),
      .blink_phase(blink_phase)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_BLANK;
         idx   <= '0;
         cnt   <= '0;
         boot  <= 1'b1;
      end else begin
         state <= state_d;
         idx   <= idx_d;
         cnt   <= cnt_d;
         boot  <= 1'b0;
      end
   end

   assign blank_done = !boot && state == S_BLANK && cnt == BLANK_LAST;
   assign on_done    = !boot && state == S_ON && cnt == ON_LAST;

   always_comb begin
      state_d     = state;
      idx_d       = idx;
      cnt_d       = cnt + 1'b1;
      boundary    = 1'b0;
      enter_blank = 1'b0;
      unique case (1'b1)
         boot: begin
            state_d     = S_BLANK;
            idx_d       = '0;
            cnt_d       = '0;
            boundary    = 1'b1;
            enter_blank = 1'b1;
         end
         blank_done: begin
            state_d = S_ON;
            cnt_d   = '0;
         end
         on_done: begin
            state_d     = S_BLANK;
            idx_d       = idx + 1'b1;
            cnt_d       = '0;
            enter_blank = 1'b1;
            boundary    = (idx == IDX_W'(N_DIGITS - 1));
         end
         default: ;
      endcase
   end

   // Outputs are computed from the next state so the registered
   // pins line up exactly with the state they belong to.
   always_comb begin
      commit   = boundary && pend_valid;
      shadow_d = commit ? pend : shadow;
      vis      = shadow.mask[idx_d] &&
                 !(shadow.blink[idx_d] && blink_phase);
      led_en_d = LED_EN_OFF;
      if (state_d == S_ON && vis)
         led_en_d = ~(8'd1 << idx_d);
      num_set_d = num_set_q;
      boom1_d   = boom1_q;
      if (enter_blank) begin
         num_set_d = nib(shadow_d.data, idx_d);
         boom1_d   = shadow_d.boom;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_en_q      <= LED_EN_OFF;
         num_set_q     <= '0;
         boom1_q       <= 1'b0;
         load_ack_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         led_en_q      <= led_en_d;
         num_set_q     <= num_set_d;
         boom1_q       <= boom1_d;
         load_ack_q    <= commit;
         frame_start_q <= boundary;
      end
   end

   // A load on the boundary cycle lands in pending after the commit,
   // so it waits for the following frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow     <= '0;
         pend       <= '0;
         pend_valid <= 1'b0;
      end else begin
         shadow <= shadow_d;
         if (bus.load) begin
            pend.data  <= bus.disp_data;
            pend.mask  <= bus.disp_mask;
            pend.blink <= bus.blink_mask;
            pend.boom  <= bus.boom_in;
            pend_valid <= 1'b1;
         end else if (commit) begin
            pend_valid <= 1'b0;
         end
      end
   end

   assign bus.led_en      = led_en_q;
   assign bus.num_set     = num_set_q;
   assign bus.boom1       = boom1_q;
   assign bus.load_ack    = load_ack_q;
   assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 ON / 2 BLANK cycles, 2 blink frames.
// Walks whole frames and checks every pin on every cycle.
module tb_seg_scan_ctrl;

   import seg_pkg::*;

   localparam int SLOT  = 6;
   localparam int FRAME = 48;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   frame_no;

   seg_scan_ctrl_if bus ();

   seg_scan_ctrl #(
      .DIGIT_CYCLES(4),
      .BLANK_CYCLES(2),
      .BLINK_FRAMES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic img_t mk(
      input logic [31:0] d,
      input logic [7:0]  m,
      input logic [7:0]  b,
      input logic        bm
   );
      img_t r;
      r.data  = d;
      r.mask  = m;
      r.blink = b;
      r.boom  = bm;
      return r;
   endfunction

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input img_t i);
      bus.disp_data  = i.data;
      bus.disp_mask  = i.mask;
      bus.blink_mask = i.blink;
      bus.boom_in    = i.boom;
      bus.load       = 1'b1;
   endtask

   // Entered at the negedge of a frame's first cycle (frame_start high);
   // leaves at the negedge of offset n.
   task automatic run_frame(
      input logic [31:0] data,
      input logic [7:0]  lit,
      input logic        boom,
      input logic        ack,
      input int          n,
      input int          la,
      input img_t        ia,
      input int          lb,
      input img_t        ib
   );
      int d;
      int p;
      logic [7:0] exp_led;
      for (int o = 0; o < n; o++) begin
         bus.load = 1'b0;
         d = o / SLOT;
         p = o % SLOT;
         exp_led = 8'hFF;
         if (p >= 2 && lit[d])
            exp_led = ~(8'd1 << d);
         chk($sformatf("led f%0d o%0d", frame_no, o),
             32'(bus.led_en), 32'(exp_led));
         chk($sformatf("num f%0d o%0d", frame_no, o),
             32'(bus.num_set), 32'(data[d*4 +: 4]));
         chk($sformatf("boom f%0d o%0d", frame_no, o),
             32'(bus.boom1), 32'(boom));
         chk($sformatf("fs f%0d o%0d", frame_no, o),
             32'(bus.frame_start), 32'(o == 0));
         chk($sformatf("ack f%0d o%0d", frame_no, o),
             32'(bus.load_ack), 32'((o == 0) && ack));
         if (o == la) drive(ia);
         if (o == lb) drive(ib);
         @(negedge clk);
      end
      frame_no++;
   endtask

   initial begin
      img_t none;
      img_t img_a;
      none   = mk(32'h0, 8'h00, 8'h00, 1'b0);
      img_a  = mk(32'h7654_3210, 8'hFF, 8'h00, 1'b0);
      checks = 0;
      errors = 0;
      frame_no = 0;
      rst = 1'b1;
      bus.disp_data  = '0;
      bus.disp_mask  = '0;
      bus.blink_mask = '0;
      bus.boom_in    = 1'b0;
      bus.load       = 1'b0;
      #1;
      chk("rst led", 32'(bus.led_en), 32'hFF);
      chk("rst num", 32'(bus.num_set), 32'h0);
      chk("rst boom", 32'(bus.boom1), 32'h0);
      chk("rst ack", 32'(bus.load_ack), 32'h0);
      chk("rst fs", 32'(bus.frame_start), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // empty image, then the basic scan with one ack
      run_frame(32'h0, 8'h00, 1'b0, 1'b0, FRAME, 10, img_a, -1, none);
      run_frame(32'h7654_3210, 8'hFF, 1'b0, 1'b1, FRAME, 10,
                mk(32'h7654_3210, 8'hFF, 8'h01, 1'b0), -1, none);

      // blink on digit 0: phase 1,0,0,1 across these frames
      run_frame(32'h7654_3210, 8'hFE, 1'b0, 1'b1, FRAME, -1, none, -1, none);
      run_frame(32'h7654_3210, 8'hFF, 1'b0, 1'b0, FRAME, -1, none, -1, none);
      run_frame(32'h7654_3210, 8'hFF, 1'b0, 1'b0, FRAME, -1, none, -1, none);
      run_frame(32'h7654_3210, 8'hFE, 1'b0, 1'b0, FRAME,
                5, mk(32'h1111_1111, 8'hFF, 8'h00, 1'b0),
                20, mk(32'h2222_2222, 8'hFF, 8'h00, 1'b0));

      // latest load wins; then a load on the boundary cycle
      run_frame(32'h2222_2222, 8'hFF, 1'b0, 1'b1, FRAME, -1, none, -1, none);
      run_frame(32'h2222_2222, 8'hFF, 1'b0, 1'b0, FRAME,
                47, mk(32'h89AB_CDEF, 8'hFF, 8'h00, 1'b0), -1, none);
      run_frame(32'h2222_2222, 8'hFF, 1'b0, 1'b0, FRAME, -1, none, -1, none);
      run_frame(32'h89AB_CDEF, 8'hFF, 1'b0, 1'b1, FRAME,
                3, mk(32'h89AB_CDEF, 8'h0F, 8'h00, 1'b1), -1, none);

      // letter mode with upper digits masked off
      run_frame(32'h89AB_CDEF, 8'h0F, 1'b1, 1'b1, FRAME, -1, none, -1, none);
      run_frame(32'h89AB_CDEF, 8'h0F, 1'b1, 1'b0, 15,
                5, mk(32'h3333_3333, 8'hFF, 8'h00, 1'b0), -1, none);

      // async reset while digit 2 is lit, with a load pending
      chk("pre-rst led", 32'(bus.led_en), 32'hFB);
      #2 rst = 1'b1;
      #1;
      chk("mid-rst led", 32'(bus.led_en), 32'hFF);
      chk("mid-rst num", 32'(bus.num_set), 32'h0);
      chk("mid-rst boom", 32'(bus.boom1), 32'h0);
      chk("mid-rst ack", 32'(bus.load_ack), 32'h0);
      chk("mid-rst fs", 32'(bus.frame_start), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_frame(32'h0, 8'h00, 1'b0, 1'b0, FRAME, 30, img_a, -1, none);
      run_frame(32'h7654_3210, 8'hFF, 1'b0, 1'b1, FRAME, -1, none, -1, none);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
